// File: rtl/atm_pkg.sv
// Shared types and defaults for the ATM transaction arbiter: opcodes, response
// codes, controller states and field widths.
package atm_pkg;

  localparam int unsigned IDX_W       = 4;
  localparam int unsigned AMT_W       = 11;
  localparam int unsigned BAL_W       = 16;
  localparam int unsigned DEF_NUM_ACC = 10;
  localparam int unsigned DEF_MAX_BAL = 2047;

  typedef enum logic [1:0] {
    OP_BALANCE  = 2'd0,
    OP_WITHDRAW = 2'd1,
    OP_TRANSFER = 2'd2,
    OP_ILLEGAL  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_BAD_IDX  = 2'd1,
    RSP_NO_FUNDS = 2'd2,
    RSP_REJECT   = 2'd3
  } rsp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_SRC,
    ST_CHK_SRC,
    ST_RD_DST,
    ST_CHK_DST,
    ST_WR_SRC,
    ST_WR_DST,
    ST_RESP
  } state_t;

endpackage

// File: rtl/atm_txn_arbiter_rr.sv
// Generic N-way round-robin arbiter: combinational one-hot grant, priority
// pointer advances past the winner whenever update is strobed.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N-1:0]                      req,
  input  logic                              update,
  output logic [N-1:0]                      grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic          found;
  int unsigned   cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!found && req[cand]) begin
        found          = 1'b1;
        grant[cand]    = 1'b1;
        grant_idx      = cand[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (update && found) begin
      ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/atm_txn_arbiter.sv
// Serialises ATM terminal transactions onto a single-port balance store as
// atomic read-check-write sequences, round-robin between terminals.
module atm_txn_arbiter
  import atm_pkg::*;
#(
  parameter int unsigned N_TERM  = 2,
  parameter int unsigned NUM_ACC = DEF_NUM_ACC,
  parameter int unsigned MAX_BAL = DEF_MAX_BAL
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_TERM-1:0]         req,
  input  logic [2*N_TERM-1:0]       op,
  input  logic [IDX_W*N_TERM-1:0]   src_idx,
  input  logic [IDX_W*N_TERM-1:0]   dst_idx,
  input  logic [AMT_W*N_TERM-1:0]   amount,
  output logic [N_TERM-1:0]         gnt,
  output logic [N_TERM-1:0]         done,
  output logic [1:0]                rsp_code,
  output logic [BAL_W-1:0]          rsp_balance,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [IDX_W-1:0]          mem_addr,
  output logic [BAL_W-1:0]          mem_wdata,
  input  logic [BAL_W-1:0]          mem_rdata
);

  localparam int unsigned TW = (N_TERM > 1) ? $clog2(N_TERM) : 1;
  localparam logic [IDX_W:0] ACC_LIM = NUM_ACC[IDX_W:0];
  localparam logic [BAL_W:0] BAL_LIM = MAX_BAL[BAL_W:0];

  state_t              state, state_nxt;
  logic [N_TERM-1:0]   arb_grant, cur_gnt;
  logic [TW-1:0]       arb_idx;
  op_t                 cur_op;
  logic [IDX_W-1:0]    cur_src, cur_dst;
  logic [AMT_W-1:0]    cur_amt;
  logic [BAL_W-1:0]    src_bal, dst_bal, amt_ext;
  logic [BAL_W:0]      dst_sum;
  rsp_t                rsp_code_q, early_code;
  logic [BAL_W-1:0]    rsp_bal_q;
  logic                early_err, short_funds, dst_ovf, arb_update;

  assign arb_update = (state == ST_IDLE) && (|req);

  rr_arbiter #(.N(N_TERM)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .update    (arb_update),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign amt_ext     = {{(BAL_W-AMT_W){1'b0}}, cur_amt};
  assign short_funds = amt_ext > mem_rdata;
  assign dst_sum     = {1'b0, mem_rdata} + {1'b0, amt_ext};
  assign dst_ovf     = dst_sum > BAL_LIM;

  // Request checks run in RD_SRC on the latched fields, so a rejected
  // request never strobes the store.
  always_comb begin
    early_err  = 1'b1;
    early_code = RSP_OK;
    if (cur_op == OP_ILLEGAL)                                  early_code = RSP_REJECT;
    else if ({1'b0, cur_src} >= ACC_LIM)                       early_code = RSP_BAD_IDX;
    else if (cur_op == OP_TRANSFER && {1'b0, cur_dst} >= ACC_LIM) early_code = RSP_BAD_IDX;
    else if (cur_op == OP_TRANSFER && cur_dst == cur_src)      early_code = RSP_REJECT;
    else                                                       early_err  = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cur_src;
    mem_wdata = '0;
    unique case (state)
      ST_IDLE:    if (|req) state_nxt = ST_RD_SRC;
      ST_RD_SRC: begin
        mem_en    = !early_err;
        state_nxt = early_err ? ST_RESP : ST_CHK_SRC;
      end
      ST_CHK_SRC: begin
        if (cur_op == OP_BALANCE || short_funds) state_nxt = ST_RESP;
        else if (cur_op == OP_WITHDRAW)          state_nxt = ST_WR_SRC;
        else                                     state_nxt = ST_RD_DST;
      end
      ST_RD_DST: begin
        mem_en    = 1'b1;
        mem_addr  = cur_dst;
        state_nxt = ST_CHK_DST;
      end
      ST_CHK_DST: state_nxt = dst_ovf ? ST_RESP : ST_WR_SRC;
      ST_WR_SRC: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = src_bal - amt_ext;
        state_nxt = (cur_op == OP_WITHDRAW) ? ST_RESP : ST_WR_DST;
      end
      ST_WR_DST: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cur_dst;
        mem_wdata = dst_bal + amt_ext;
        state_nxt = ST_RESP;
      end
      ST_RESP:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur_gnt    <= '0;
      cur_op     <= OP_BALANCE;
      cur_src    <= '0;
      cur_dst    <= '0;
      cur_amt    <= '0;
      src_bal    <= '0;
      dst_bal    <= '0;
      rsp_code_q <= RSP_OK;
      rsp_bal_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (|req) begin
          cur_gnt <= arb_grant;
          cur_op  <= op_t'(op[2*arb_idx +: 2]);
          cur_src <= src_idx[IDX_W*arb_idx +: IDX_W];
          cur_dst <= dst_idx[IDX_W*arb_idx +: IDX_W];
          cur_amt <= amount[AMT_W*arb_idx +: AMT_W];
        end
        ST_RD_SRC: if (early_err) begin
          rsp_code_q <= early_code;
          rsp_bal_q  <= '0;
        end
        ST_CHK_SRC: begin
          src_bal   <= mem_rdata;
          rsp_bal_q <= mem_rdata;
          if (cur_op == OP_BALANCE) rsp_code_q <= RSP_OK;
          else if (short_funds)     rsp_code_q <= RSP_NO_FUNDS;
        end
        ST_CHK_DST: begin
          dst_bal <= mem_rdata;
          if (dst_ovf) rsp_code_q <= RSP_REJECT;
        end
        ST_WR_SRC: begin
          rsp_code_q <= RSP_OK;
          rsp_bal_q  <= src_bal - amt_ext;
        end
        default: ;
      endcase
    end
  end

  assign gnt         = (state != ST_IDLE) ? cur_gnt : '0;
  assign done        = (state == ST_RESP) ? cur_gnt : '0;
  assign rsp_code    = rsp_code_q;
  assign rsp_balance = rsp_bal_q;

endmodule
